nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder built around one 4-bit carry_look_ahead_adder instance.
//   Captures a, b and cin on an input handshake, then feeds the CLA one nibble per cycle (LSB first).
//   The block registers the CLA carry-out between nibbles and assembles the result word.
//   Sits directly upstream of the CLA and consumes its sum/cout; presents a valid/ready result port.
// PARAMETERS
//   WIDTH    16   operand/result width in bits; must be a multiple of 4 and >= 8
//   NIBBLES  WIDTH/4  localparam: number of ADD cycles per operation
// PORTS
//   clk        in   1      single clock; all state updates on posedge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a/b/cin valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to bit 0
//   out_valid  out  1      sum/cout valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in ADD or DONE
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, out_valid=0, sum=0, cout=0, carry reg=0, nibble idx=0.
//     Reset mid-operation aborts. No result is produced, and the next cycle is IDLE with in_ready=1.
//   FSM states: IDLE -> ADD -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, capture a->a_sh, b->b_sh, cin->carry; idx=0; go to ADD.
//   ADD: CLA inputs are a_sh[3:0], b_sh[3:0] and carry. Each posedge:
//     sum_sh <= {cla_sum, sum_sh[WIDTH-1:4]}; carry <= cla_cout;
//     a_sh, b_sh shift right by 4; idx <= idx+1.
//     When idx==NIBBLES-1, the final sum_sh and carry are loaded into sum and cout, and the FSM goes to DONE.
//   DONE: out_valid=1. sum/cout are held stable. On out_valid&out_ready, go to IDLE.
//     Back-to-back: the next accept is possible on the cycle after the output handshake.
//   Latency: accept at edge k; out_valid is first high after edge k+NIBBLES (4 edges for WIDTH=16).
//   in_valid is ignored outside IDLE. Operands need not be held after the accepting edge.
//   With out_ready low, DONE persists indefinitely; sum, cout and out_valid do not change.
//   sum and cout retain the last result after leaving DONE (until the next result load or reset).
//   Arithmetic: unsigned; {cout,sum} = a + b + cin exactly. Carry chains across all nibbles.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined:
//     Adds output port 'ovf' (out, 1): two's-complement signed overflow.
//     ovf = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1] ^ cout, using the operand MSBs captured at accept.
//     ovf loads with sum/cout, resets to 0, and is held like sum.
//   OVERFLOW_FLAG_EN not defined: no ovf port and no MSB capture registers. Behaviour is otherwise identical.
// TESTING (WIDTH=16)
//   1. rst 2 cycles, then accept a=0x0000, b=0x0000, cin=0 -> after 4 edges out_valid=1, sum=0x0000, cout=0.
//   2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry through all 4 nibbles).
//   3. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; a=0x8888, b=0x8888, cin=1 -> sum=0x1111, cout=1.
//   4. Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands
//      -> out_valid stays 1, sum is unchanged, in_ready=0, and the new operands are not taken.
//   5. Assert rst on the 2nd ADD cycle -> next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
//   6. With OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1;
//      0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1; 0x0001+0x0001 -> ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Bundles the operand handshake and the result handshake of nibble_serial_adder.
//   Parameter:
//     WIDTH      operand/result width in bits
//   Signals:
//     in_valid   operands a/b/cin are valid               (master -> slave)
//     in_ready   adder can accept operands                (slave  -> master)
//     a, b       operands, WIDTH bits                     (master -> slave)
//     cin        carry-in to bit 0                        (master -> slave)
//     out_valid  sum/cout are valid                       (slave  -> master)
//     out_ready  consumer accepts the result              (master -> slave)
//     sum        a + b + cin modulo 2^WIDTH               (slave  -> master)
//     cout       carry out of bit WIDTH-1                 (slave  -> master)
//     busy       adder is in ADD or DONE                  (slave  -> master)
//     ovf        signed overflow, only when OVERFLOW_FLAG_EN is defined
//   Modports: master (operand producer / result consumer), slave (the adder).
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef OVERFLOW_FLAG_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef OVERFLOW_FLAG_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit unsigned adder that reuses a single 4-bit carry
//   look-ahead adder, one nibble per cycle, least significant nibble first.
//   Operands are captured on the input handshake; the result is offered on a
//   valid/ready output port and held until the next result or reset.
//   Optional feature macro: OVERFLOW_FLAG_EN adds the 'ovf' signed-overflow
//   output (carried in the interface) plus registers for the operand MSBs.
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous, active-high reset
//     bus   nibble_serial_adder_if.slave (in/out handshakes, a, b, cin, sum,
//           cout, busy and optionally ovf)
//   Contents: carry_look_ahead_adder (4-bit CLA) and nibble_serial_adder (top).

// 4-bit carry look-ahead adder: all carries are formed directly from the
// generate/propagate terms rather than rippling.
module carry_look_ahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
`ifdef OVERFLOW_FLAG_EN
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             ovf_q,    ovf_d;
`endif

    logic [3:0] cla_sum;
    logic       cla_cout;

    // The CLA always sees the bottom nibble of the shifting operands; its
    // outputs only matter while in ADD.
    carry_look_ahead_adder u_cla (
        .a    (a_sh_q[3:0]),
        .b    (b_sh_q[3:0]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // Next-state logic: accept operands in IDLE, consume one nibble per cycle
    // in ADD, and hold the finished result in DONE until it is taken.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef OVERFLOW_FLAG_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
`ifdef OVERFLOW_FLAG_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                    state_d = ADD;
                end
            end
            ADD: begin
                // New nibbles enter at the top so the last one lands in place.
                sum_sh_d = {cla_sum, sum_sh_q[WIDTH-1:4]};
                carry_d  = cla_cout;
                a_sh_d   = {4'b0000, a_sh_q[WIDTH-1:4]};
                b_sh_d   = {4'b0000, b_sh_q[WIDTH-1:4]};
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    sum_d   = sum_sh_d;
                    cout_d  = cla_cout;
`ifdef OVERFLOW_FLAG_EN
                    // Carry into the MSB xor carry out of it.
                    ovf_d   = a_msb_q ^ b_msb_q ^ sum_sh_d[WIDTH-1] ^ cla_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-operation simply
    // discards the partial sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef OVERFLOW_FLAG_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ADD) || (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule
